pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Sequences the fetch PC from the EX-stage branch decision (pc_sel: PC_4, PC_BRJMP, PC_JALR, PC_EXC) and exception redirects.
- Owns the architectural fetch PC register and the fetch-request handshake.
- Runs a timed flush of the IF and ID stages after every taken redirect, during which further EX redirects are blocked.
- Sits between the branch-decision logic in EX and the instruction-fetch port.

Parameters:
- XLEN, 32, PC and target width.
- RESET_PC, 32'h0000_0200, PC loaded on reset.
- KILL_CYCLES, 2, number of cycles kill_if/kill_id are held after a redirect; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  EX holds a valid branch decision this cycle.
- ex_pc_sel  in  2  0=PC_4, 1=PC_BRJMP, 2=PC_JALR, 3=PC_EXC.
- ex_br_target  in  XLEN  branch/JAL target.
- ex_jalr_target  in  XLEN  raw JALR sum (rs1+imm).
- exc_valid  in  1  exception/trap request from commit.
- exc_vector  in  XLEN  trap handler address.
- fetch_ready  in  1  fetch port accepts a request.
- fetch_valid  out  1  request valid.
- fetch_pc  out  XLEN  requested PC.
- kill_if  out  1  squash the IF-stage instruction.
- kill_id  out  1  squash the ID-stage instruction.
- stall_ex  out  1  EX must hold; decision not consumed.
- redirect_taken  out  1  one-cycle pulse, registered, on every accepted redirect.

Behaviour:
- Reset, synchronous, wins over everything including mid-flush: state=RUN, pc=RESET_PC, flush count=0. Outputs the cycle after reset deasserts: fetch_valid=1, fetch_pc=RESET_PC, kill_if=kill_id=stall_ex=redirect_taken=0.
- States:
  - RUN: fetch_valid=1, kills=0.
  - FLUSH: fetch_valid=0, kill_if=kill_id=1, stall_ex=1.
- Targets:
  - PC_BRJMP: ex_br_target.
  - PC_JALR: ex_jalr_target with bit0 forced to 0.
  - PC_EXC (from EX or exc_valid): exc_vector.
- Redirect condition in RUN: (ex_valid && ex_pc_sel!=PC_4) || exc_valid.
  - exc_valid has priority; its target is exc_vector regardless of ex_pc_sel.
  - Accepted at edge T: pc<=target, state<=FLUSH, cnt<=KILL_CYCLES-1, redirect_taken=1 for cycle T+1.
  - A redirect in RUN is accepted whatever fetch_ready is; the in-flight sequential request is discarded.
- Sequential advance in RUN with no redirect: if fetch_valid && fetch_ready, pc<=pc+4 (mod 2^XLEN, wraps silently); else pc holds.
- ex_valid with PC_4 never changes state.
- FLUSH:
  - Lasts exactly KILL_CYCLES cycles. Each cycle, if cnt==0 go to RUN, else cnt--.
  - EX redirects are ignored; stall_ex keeps EX holding them.
  - exc_valid in FLUSH is accepted: pc<=exc_vector, cnt reloads to KILL_CYCLES-1, redirect_taken pulses.
- stall_ex=0 in RUN.
- fetch_pc always equals the pc register; there is no combinational path from ex_* to fetch_pc.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_exc (1 bit, registered, reset 0).
  - A PC_BRJMP or PC_JALR target with bit1 set (after JALR bit0 clear) redirects to exc_vector instead and pulses misalign_exc with redirect_taken.
  - misalign_exc has lower priority than exc_valid: if both occur in the same cycle, misalign_exc stays 0.
- Undefined: no port is added; misaligned targets are used as computed.

Test Plan:
- Reset release, fetch_ready=1 for 4 cycles -> fetch_pc 0x200, 0x204, 0x208, 0x20C; kills 0.
- fetch_ready=0 for 3 cycles at pc 0x204 -> fetch_pc holds 0x204, then resumes 0x208.
- ex_valid, PC_BRJMP, target 0x1000 -> next cycle redirect_taken=1, fetch_valid=0 and kills=1 for 2 cycles, then fetch_pc=0x1000. A second BRJMP during the flush is ignored while stall_ex=1.
- PC_JALR with raw 0x2003 -> fetch_pc 0x2002. With MISALIGN_TRAP_EN and exc_vector=0x100 -> misalign_exc=1, fetch_pc 0x100.
- exc_valid=1 with ex PC_BRJMP 0x3000 in the same cycle -> fetch_pc=exc_vector. exc_valid in the 2nd flush cycle -> flush restarts, 2 more kill cycles.
- reset asserted during FLUSH -> next cycle RUN, fetch_pc=0x200, kills 0; pc at 0xFFFF_FFFC advances to 0x0000_0000.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: owns the fetch PC, applies EX/exception redirects and
// runs a timed IF/ID flush. Optional `MISALIGN_TRAP_EN traps misaligned targets.
module pc_redirect_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0000_0200),
  parameter int              KILL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [1:0]      ex_pc_sel,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic [XLEN-1:0] ex_jalr_target,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_vector,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            kill_if,
  output logic            kill_id,
  output logic            stall_ex,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign_exc,
`endif
  output logic            redirect_taken
);

  localparam logic [1:0] PC_4     = 2'd0;
  localparam logic [1:0] PC_BRJMP = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(KILL_CYCLES - 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [3:0]      r_cnt;
  logic            r_fetch_valid;
  logic            r_kill;
  logic            r_redirect;

  logic            w_ex_redir;
  logic [XLEN-1:0] w_target;
  logic            w_misalign;

  assign w_ex_redir = ex_valid && (ex_pc_sel != PC_4);

  // Exception target wins over any EX decision in the same cycle.
  always_comb begin
    w_target   = exc_vector;
    w_misalign = 1'b0;
    if (!exc_valid) begin
      case (ex_pc_sel)
        PC_BRJMP: w_target = ex_br_target;
        PC_JALR:  w_target = {ex_jalr_target[XLEN-1:1], 1'b0};
        default:  w_target = exc_vector;
      endcase
`ifdef MISALIGN_TRAP_EN
      if ((ex_pc_sel == PC_BRJMP || ex_pc_sel == PC_JALR) && w_target[1]) begin
        w_target   = exc_vector;
        w_misalign = 1'b1;
      end
`endif
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_cnt         <= '0;
      r_fetch_valid <= 1'b1;
      r_kill        <= 1'b0;
      r_redirect    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_redirect <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        S_RUN: begin
          if (exc_valid || w_ex_redir) begin
            // The in-flight sequential request is dropped regardless of fetch_ready.
            r_pc          <= w_target;
            r_state       <= S_FLUSH;
            r_cnt         <= CNT_INIT;
            r_fetch_valid <= 1'b0;
            r_kill        <= 1'b1;
            r_redirect    <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            r_misalign    <= w_misalign;
`endif
          end else if (r_fetch_valid && fetch_ready) begin
            r_pc <= r_pc + XLEN'(4);
          end
        end
        S_FLUSH: begin
          if (exc_valid) begin
            r_pc       <= exc_vector;
            r_cnt      <= CNT_INIT;
            r_redirect <= 1'b1;
          end else if (r_cnt == 4'd0) begin
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b1;
            r_kill        <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state       <= S_RUN;
          r_fetch_valid <= 1'b1;
          r_kill        <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid    = r_fetch_valid;
  assign fetch_pc       = r_pc;
  assign kill_if        = r_kill;
  assign kill_id        = r_kill;
  assign stall_ex       = r_kill;
  assign redirect_taken = r_redirect;
`ifdef MISALIGN_TRAP_EN
  assign misalign_exc   = r_misalign;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a remaining-flush-cycles reference model.
module tb_pc_redirect_ctrl;
  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0200;
  localparam int          K    = 2;

  logic        clk, reset, ex_valid, exc_valid, fetch_ready;
  logic [1:0]  ex_pc_sel;
  logic [31:0] ex_br_target, ex_jalr_target, exc_vector;
  logic        fetch_valid, kill_if, kill_id, stall_ex, redirect_taken;
  logic [31:0] fetch_pc;
  logic        misalign_exc;

  pc_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .KILL_CYCLES(K)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc_sel(ex_pc_sel),
    .ex_br_target(ex_br_target), .ex_jalr_target(ex_jalr_target),
    .exc_valid(exc_valid), .exc_vector(exc_vector), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .kill_if(kill_if),
    .kill_id(kill_id), .stall_ex(stall_ex),
`ifdef MISALIGN_TRAP_EN
    .misalign_exc(misalign_exc),
`endif
    .redirect_taken(redirect_taken));

`ifndef MISALIGN_TRAP_EN
  assign misalign_exc = 1'b0;
`endif

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int checks = 0, failures = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pc, number of flush cycles still to run, and pulse outputs.
  logic [31:0] m_pc;
  int          m_left;
  bit          m_rt, m_mis;

  always @(posedge clk) begin
    logic [31:0] t;
    bit mis;
    t = exc_vector; mis = 0;
    if (!exc_valid) begin
      if (ex_pc_sel == 2'd1) t = ex_br_target;
      else if (ex_pc_sel == 2'd2) t = ex_jalr_target & 32'hFFFF_FFFE;
`ifdef MISALIGN_TRAP_EN
      if ((ex_pc_sel == 2'd1 || ex_pc_sel == 2'd2) && (t % 4 >= 2)) begin
        t = exc_vector; mis = 1;
      end
`endif
    end
    m_rt = 0; m_mis = 0;
    if (reset) begin
      m_pc = RPC; m_left = 0;
    end else if (m_left == 0) begin
      if (exc_valid || (ex_valid && ex_pc_sel != 2'd0)) begin
        m_pc = t; m_left = K; m_rt = 1; m_mis = mis;
      end else if (fetch_ready) m_pc = m_pc + 32'd4;
    end else if (exc_valid) begin
      m_pc = exc_vector; m_left = K; m_rt = 1;
    end else m_left = m_left - 1;
    #1;
    if (chk_en) begin
      chk("model_fetch_valid", 32'(fetch_valid), 32'(m_left == 0));
      chk("model_kill_if",     32'(kill_if),     32'(m_left != 0));
      chk("model_kill_id",     32'(kill_id),     32'(m_left != 0));
      chk("model_stall_ex",    32'(stall_ex),    32'(m_left != 0));
      chk("model_fetch_pc",    fetch_pc,         m_pc);
      chk("model_redirect",    32'(redirect_taken), 32'(m_rt));
      chk("model_misalign",    32'(misalign_exc),   32'(m_mis));
    end
  end

  task automatic step(); @(posedge clk); #2; endtask

  task automatic expect_o(input string nm, input bit fv, input bit kl, input bit rt,
                          input logic [31:0] pc);
    chk({nm, "_fv"},   32'(fetch_valid), 32'(fv));
    chk({nm, "_kill"}, 32'(kill_if & kill_id & stall_ex), 32'(kl));
    chk({nm, "_rt"},   32'(redirect_taken), 32'(rt));
    chk({nm, "_pc"},   fetch_pc, pc);
  endtask

  initial begin
    reset = 1; ex_valid = 0; ex_pc_sel = 0; ex_br_target = 0; ex_jalr_target = 0;
    exc_valid = 0; exc_vector = 32'h100; fetch_ready = 0;
    step();
    chk_en = 1;
    reset = 0; fetch_ready = 1;
    expect_o("reset_state", 1, 0, 0, 32'h200);
    step(); expect_o("seq1", 1, 0, 0, 32'h204);
    step(); expect_o("seq2", 1, 0, 0, 32'h208);
    step(); expect_o("seq3", 1, 0, 0, 32'h20C);

    reset = 1; step(); reset = 0; step();
    expect_o("to_204", 1, 0, 0, 32'h204);
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin step(); expect_o("hold", 1, 0, 0, 32'h204); end
    fetch_ready = 1; step(); expect_o("resume", 1, 0, 0, 32'h208);

    ex_valid = 1; ex_pc_sel = 2'd1; ex_br_target = 32'h1000;
    step(); expect_o("br_taken", 0, 1, 1, 32'h1000);
    ex_br_target = 32'h5000;
    step(); expect_o("br_flush2", 0, 1, 0, 32'h1000);
    ex_valid = 0;
    step(); expect_o("br_run", 1, 0, 0, 32'h1000);

    ex_valid = 1; ex_pc_sel = 2'd2; ex_jalr_target = 32'h2003; exc_vector = 32'h100;
    step();
`ifdef MISALIGN_TRAP_EN
    expect_o("jalr_trap", 0, 1, 1, 32'h100);
    chk("jalr_misalign", 32'(misalign_exc), 32'd1);
`else
    expect_o("jalr", 0, 1, 1, 32'h2002);
`endif
    ex_valid = 0; step(); step();

    exc_valid = 1; exc_vector = 32'h800; ex_valid = 1; ex_pc_sel = 2'd1; ex_br_target = 32'h3000;
    step(); expect_o("exc_prio", 0, 1, 1, 32'h800);
    chk("exc_prio_mis", 32'(misalign_exc), 32'd0);
    exc_valid = 0; ex_valid = 0;
    step(); expect_o("exc_f2", 0, 1, 0, 32'h800);
    exc_valid = 1; exc_vector = 32'h900;
    step(); expect_o("exc_restart", 0, 1, 1, 32'h900);
    exc_valid = 0;
    step(); expect_o("restart_f2", 0, 1, 0, 32'h900);
    step(); expect_o("restart_run", 1, 0, 0, 32'h900);

    ex_valid = 1; ex_pc_sel = 2'd1; ex_br_target = 32'h4000;
    step(); ex_valid = 0; reset = 1;
    step(); reset = 0;
    expect_o("reset_in_flush", 1, 0, 0, 32'h200);

    ex_valid = 1; ex_pc_sel = 2'd1; ex_br_target = 32'hFFFF_FFFC;
    step(); ex_valid = 0; step(); step();
    expect_o("at_top", 1, 0, 0, 32'hFFFF_FFFC);
    fetch_ready = 1; step(); expect_o("wrap", 1, 0, 0, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      ex_valid       = $urandom_range(0, 1);
      ex_pc_sel      = 2'($urandom_range(0, 3));
      ex_br_target   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      ex_jalr_target = $urandom;
      exc_valid      = ($urandom_range(0, 15) == 0);
      exc_vector     = $urandom & 32'hFFFF_FFFC;
      fetch_ready    = ($urandom_range(0, 3) != 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
